// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and the store-buffer entry layout
package mem_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WORD_OFF = 2;
    typedef struct packed {
        logic valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd: youngest-match search over the pending entries for load forwarding
module store_buffer_fwd
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW = $clog2(DEPTH),
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  entry_t ents [DEPTH],
    input  logic [PW-1:0] rd_ptr,
    input  logic [CW-1:0] count,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic hit,
    output logic [DATA_W-1:0] data
);
    logic [PW-1:0] idx;
    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit = 1'b0;
        data = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count && ents[idx].valid &&
                ents[idx].addr[ADDR_W-1:WORD_OFF] == ld_addr[ADDR_W-1:WORD_OFF]) begin
                hit = 1'b1;
                data = ents[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of data memory with load forwarding
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic st_ready,
    input  logic ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic ld_hit,
    output logic empty,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic mem_memWrite,
    output logic mem_memRead,
    input  logic [DATA_W-1:0] mem_readData
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    entry_t ents [DEPTH];
    entry_t head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic fwd_hit, ld_act, miss, drain, enq;
    logic [DATA_W-1:0] fwd_data;

    store_buffer_fwd #(.DEPTH(DEPTH)) u_fwd (
        .ents(ents),
        .rd_ptr(rd_ptr),
        .count(count),
        .ld_addr(ld_addr),
        .hit(fwd_hit),
        .data(fwd_data)
    );

    // Load miss owns the memory port; the drain waits a cycle.
    always_comb begin
        head = ents[rd_ptr];
        st_ready = count != CW'(DEPTH);
        empty = count == '0;
        enq = st_valid && st_ready;
        ld_act = ld_valid && rst_n;
        ld_hit = ld_act && fwd_hit;
        miss = ld_act && !fwd_hit;
        drain = !miss && !empty;
        ld_data = ld_hit ? fwd_data : miss ? mem_readData : '0;
        mem_memRead = miss;
        mem_memWrite = drain;
        mem_address = miss ? ld_addr : drain ? head.addr : '0;
        mem_writeData = drain ? head.data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
        end else begin
            if (drain) begin
                ents[rd_ptr].valid <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq) begin
                ents[wr_ptr] <= '{valid: 1'b1, addr: st_addr, data: st_data};
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + CW'(enq) - CW'(drain);
        end
    end
endmodule
